// File: rtl/uart_pkg.sv
// Shared definitions for the SoC UART receiver and transmitter: frame size,
// receiver state encoding and the baud divider helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } uart_rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is a
// parameter so idle-high lines (rx) and idle-low lines (btn, sw) both fit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 serial byte receiver: synchronises rx, samples each bit at mid-bit and
// presents the received byte on a valid/ready handshake.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(CPB);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t              state_q;
    logic [CW-1:0]               cnt_q;
    logic [2:0]                  bit_idx_q;
    logic [UART_DATA_BITS-1:0]   shift_q;

    logic [UART_DATA_BITS-1:0]   data_q;
    logic                        data_valid_q;
    logic                        frame_err_q;
    logic                        overrun_q;

    logic cnt_done;
    logic stop_ok;
    logic stop_bad;
    logic accept;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    assign cnt_done = (cnt_q == '0);
    assign stop_ok  = (state_q == RX_STOP) && cnt_done && rx_s;
    assign stop_bad = (state_q == RX_STOP) && cnt_done && !rx_s;
    // valid/ready: a byte transfers on any cycle where data_valid and
    // data_ready are both 1; data stays stable while data_valid is 1.
    assign accept   = data_valid_q && data_ready;

    // Frame recovery: state, bit-time counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        cnt_q   <= HALF_LOAD;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_done) begin
                        if (!rx_s) begin
                            cnt_q     <= FULL_LOAD;
                            bit_idx_q <= '0;
                            state_q   <= RX_DATA;
                        end else begin
                            state_q <= RX_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt_done) begin
                        shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        cnt_q     <= FULL_LOAD;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RX_STOP: begin
                    // Leaving at mid-stop-bit lets a directly following start edge be caught.
                    if (cnt_done) begin
                        state_q <= rx_s ? RX_IDLE : RX_WAIT_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    // Output byte register, handshake and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            overrun_q   <= 1'b0;
            if (stop_ok && (!data_valid_q || accept)) begin
                data_q       <= shift_q;
                data_valid_q <= 1'b1;
            end else if (stop_ok) begin
                overrun_q <= 1'b1;
            end else if (accept) begin
                data_valid_q <= 1'b0;
            end
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 100 MHz / 1 Mbaud (100 clocks per bit).
`timescale 1ns/1ps
module tb_uart_byte_rx;

    localparam int CPB = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       data_ready = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int dv_len = 0;
    logic dv_prev = 1'b0;
    int acc_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int last_acc = 0;
    int prev_acc = 0;
    int busy_run = 0;
    int busy_max = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] byte_val;
        logic       stop_bit;
        logic       exp_valid;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[6];

    uart_byte_rx #(.CLK_FREQ(100000000), .BAUD(1000000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        #1;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err || overrun) begin
            checks++;
            if (frame_err && overrun) begin
                errors++;
                $display("FAIL pulse_exclusive: frame_err=%0b overrun=%0b required not both", frame_err, overrun);
            end
        end
        if (data_valid) begin
            if (!dv_prev) begin
                rise_cyc = cyc;
                dv_len = 1;
            end else begin
                dv_len++;
            end
        end
        dv_prev = data_valid;
        if (busy) begin
            busy_run++;
            if (busy_run > busy_max) busy_max = busy_run;
        end else begin
            busy_run = 0;
        end
        if (data_valid && data_ready) begin
            acc_cnt++;
            prev_acc = last_acc;
            last_acc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %02h required none", data);
            end else begin
                e = exp_q.pop_front();
                if (data !== e) begin
                    errors++;
                    $display("FAIL rx_byte: got %02h required %02h", data, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at a negedge with rx left at the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, {24'd0, data}, 32'h00);
        check({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int a0, f0, o0;

        vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hC3, 1'b0, 1'b0, 1'b1};

        // reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(5);

        // single byte, latency and one-cycle valid
        a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
        exp_q.push_back(8'h41);
        send_byte(8'h41, 1'b1);
        idle(20);
        check("single_latency", rise_cyc - start_cyc, 953);
        check("single_valid_len", dv_len, 1);
        check("single_count", acc_cnt - a0, 1);
        check("single_frame_err", fe_cnt - f0, 0);
        check("single_overrun", ov_cnt - o0, 0);

        // back-to-back bytes
        a0 = acc_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        idle(20);
        check("b2b_count", acc_cnt - a0, 2);
        check("b2b_spacing", last_acc - prev_acc, 1000);

        // table-driven single frames
        for (int v = 0; v < 6; v++) begin
            a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
            if (vecs[v].exp_valid) exp_q.push_back(vecs[v].byte_val);
            send_byte(vecs[v].byte_val, vecs[v].stop_bit);
            idle(150);
            check("vec_valid", acc_cnt - a0, {31'd0, vecs[v].exp_valid});
            check("vec_frame_err", fe_cnt - f0, {31'd0, vecs[v].exp_fe});
            check("vec_overrun", ov_cnt - o0, 0);
        end

        // framing error held as a break, then recovery
        a0 = acc_cnt; f0 = fe_cnt;
        send_byte(8'hA5, 1'b0);
        repeat (200) @(negedge clk);
        check("fe_busy_held", {31'd0, busy}, 32'd1);
        check("fe_pulse", fe_cnt - f0, 1);
        check("fe_no_valid", acc_cnt - a0, 0);
        idle(5);
        check("fe_busy_released", {31'd0, busy}, 32'd0);
        idle(20);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        idle(20);
        check("fe_recover", acc_cnt - a0, 1);

        // false start: 300 ns glitch
        a0 = acc_cnt; f0 = fe_cnt;
        busy_max = 0;
        rx = 1'b0;
        repeat (30) @(negedge clk);
        idle(200);
        check("glitch_busy_le52", {31'd0, busy_max <= 52}, 32'd1);
        check("glitch_busy_seen", {31'd0, busy_max > 0}, 32'd1);
        check("glitch_no_valid", acc_cnt - a0, 0);
        check("glitch_no_fe", fe_cnt - f0, 0);

        // overrun with consumer stalled
        a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
        data_ready = 1'b0;
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(10);
        check("ovr_data_kept", {24'd0, data}, 32'h12);
        check("ovr_valid_held", {31'd0, data_valid}, 32'd1);
        check("ovr_pulse", ov_cnt - o0, 1);
        check("ovr_no_fe", fe_cnt - f0, 0);
        data_ready = 1'b1;
        idle(3);
        check("ovr_consumed", acc_cnt - a0, 1);
        check("ovr_valid_drop", {31'd0, data_valid}, 32'd0);

        // acceptance in the same cycle a new byte completes
        a0 = acc_cnt; o0 = ov_cnt;
        data_ready = 1'b0;
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h99);
        send_byte(8'h66, 1'b1);
        fork
            send_byte(8'h99, 1'b1);
            begin
                repeat (952) @(negedge clk);
                data_ready = 1'b1;
            end
        join
        idle(10);
        check("same_cycle_count", acc_cnt - a0, 2);
        check("same_cycle_no_ovr", ov_cnt - o0, 0);

        // reset in bit 4 of 0x7E
        a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h7E >> i) & 8'h01;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        idle(1100);
        check("midrst_no_valid", acc_cnt - a0, 0);
        check("midrst_no_fe", fe_cnt - f0, 0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        idle(20);
        check("midrst_next", acc_cnt - a0, 1);
        check("midrst_no_ovr", ov_cnt - o0, 0);

        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
